fft_stream_src: RTL and testbench

//  Input framer that drives the pipelined radix-4 FFT chain from its head end.
//  - Accepts natural-order complex samples over a valid/ready handshake.
//  - Emits them as the FFT block-floating-point stream: block_sync/stage_sync/data_val

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_src_blkcnt.sv | 51 +++++
 rtl/fft_stream_src.sv | 159 +++++++++++++++
 tb/tb_fft_stream_src.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: mantissa/exponent widths, framer FSM states,
// transform-length limits and the N = 1 << ldn helper.

`ifndef MAN_WIDTH
`define MAN_WIDTH 18
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

package fft_pkg;

   localparam int MAN_W  = `MAN_WIDTH;
   localparam int EXP_W  = `EXP_WIDTH;
   localparam int CNT_W  = 11;
   localparam int LDN_W  = 4;
   localparam int LDN_LO = 2;
   localparam int LDN_HI = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_PAD    = 2'd2,
      ST_GAP    = 2'd3
   } src_state_t;

   // Transform length for a given log2 size
   function automatic logic [CNT_W:0] fft_n(input logic [LDN_W-1:0] ldn);
      return (CNT_W+1)'(1) << ldn;
   endfunction

endpackage

// File: rtl/fft_src_blkcnt.sv
// Block sample counter and inter-block gap counter for the FFT framer,
// with terminal-count flags (last sample of block, last gap cycle).

module fft_src_blkcnt
   import fft_pkg::*;
#(
   parameter int MIN_GAP = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_blk_ld,
   input  logic             i_blk_inc,
   input  logic [LDN_W-1:0] i_ldn,
   input  logic             i_gap_run,
   output logic             o_blk_tc,
   output logic             o_gap_tc
);

   localparam int GW = $clog2(MIN_GAP + 2);
   localparam int GL = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

   logic [CNT_W-1:0] r_blk_cnt;
   logic [GW-1:0]    r_gap_cnt;
   logic [CNT_W-1:0] w_n_m1;

   assign w_n_m1 = CNT_W'(fft_n(i_ldn) - (CNT_W+1)'(1));

   // Samples sent in the current block; a block start counts as one
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_blk_cnt <= '0;
      else if (i_blk_ld)
         r_blk_cnt <= CNT_W'(1);
      else if (i_blk_inc)
         r_blk_cnt <= r_blk_cnt + CNT_W'(1);
   end

   // Cycles spent in the gap; held at zero outside it
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_gap_cnt <= '0;
      else if (i_gap_run)
         r_gap_cnt <= r_gap_cnt + GW'(1);
      else
         r_gap_cnt <= '0;
   end

   assign o_blk_tc = (r_blk_cnt == w_n_m1);
   assign o_gap_tc = (r_gap_cnt == GW'(GL));

endmodule

// File: rtl/fft_stream_src.sv
// Head-end framer for the radix-4 FFT chain: natural-order samples in,
// block-framed BFP stream out. Optional zero padding: FFT_SRC_ZERO_PAD_EN.

module fft_stream_src
   import fft_pkg::*;
#(
   parameter int                IN_WIDTH = 16,
   parameter int                MIN_GAP  = 4,
   parameter logic [EXP_W-1:0]  EXP_INIT = '0,
   parameter int                LDN_MIN  = LDN_LO,
   parameter int                LDN_MAX  = LDN_HI
) (
   input  logic                clk_sys,
   input  logic                rst_sys,
   input  logic                in_val_i,
   output logic                in_rdy_o,
   input  logic [IN_WIDTH-1:0] in_real_i,
   input  logic [IN_WIDTH-1:0] in_imag_i,
   input  logic                in_last_i,
   input  logic [LDN_W-1:0]    ldn_rg_i,
   output logic                block_sync_o,
   output logic                stage_sync_o,
   output logic                data_val_o,
   output logic [MAN_W-1:0]    data_real_o,
   output logic [MAN_W-1:0]    data_imag_o,
   output logic [EXP_W-1:0]    data_exp_o,
   output logic [LDN_W-1:0]    ldn_rg_o,
   output logic                cfg_err_o
);

   src_state_t r_state;
   src_state_t w_next;
   src_state_t w_done_st;

   logic w_xfer;
   logic w_ldn_ok;
   logic w_start;
   logic w_blk_inc;
   logic w_blk_tc;
   logic w_gap_tc;
   logic w_val;
   logic w_err;
   logic w_pad;

   logic [MAN_W-1:0] w_re_x;
   logic [MAN_W-1:0] w_im_x;
   logic [MAN_W-1:0] w_re;
   logic [MAN_W-1:0] w_im;

   logic             r_val;
   logic             r_sync;
   logic             r_err;
   logic [MAN_W-1:0] r_re;
   logic [MAN_W-1:0] r_im;
   logic [EXP_W-1:0] r_exp;
   logic [LDN_W-1:0] r_ldn;

   assign in_rdy_o  = ~rst_sys & ((r_state == ST_IDLE) |
                                  (r_state == ST_STREAM));
   assign w_xfer    = in_val_i & in_rdy_o;
   assign w_ldn_ok  = (ldn_rg_i >= LDN_W'(LDN_MIN)) &
                      (ldn_rg_i <= LDN_W'(LDN_MAX));
   assign w_start   = (r_state == ST_IDLE) & w_xfer & w_ldn_ok;
   assign w_blk_inc = ((r_state == ST_STREAM) & w_xfer) |
                      (r_state == ST_PAD);
   assign w_done_st = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;

`ifdef FFT_SRC_ZERO_PAD_EN
   logic w_pad_go;
   assign w_pad_go = in_last_i &
                     (w_start | ((r_state == ST_STREAM) &
                                 w_xfer & ~w_blk_tc));
`else
   logic w_unused_last;
   assign w_unused_last = in_last_i;
`endif

   fft_src_blkcnt #(
      .MIN_GAP (MIN_GAP)
   ) u_blkcnt (
      .i_clk     (clk_sys),
      .i_rst     (rst_sys),
      .i_blk_ld  (w_start),
      .i_blk_inc (w_blk_inc),
      .i_ldn     (r_ldn),
      .i_gap_run (r_state == ST_GAP),
      .o_blk_tc  (w_blk_tc),
      .o_gap_tc  (w_gap_tc)
   );

   // State register
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_start) w_next = ST_STREAM;
         ST_STREAM: if (w_xfer & w_blk_tc) w_next = w_done_st;
         ST_GAP:    if (w_gap_tc) w_next = ST_IDLE;
`ifdef FFT_SRC_ZERO_PAD_EN
         ST_PAD:    if (w_blk_tc) w_next = w_done_st;
`endif
         default:   w_next = ST_IDLE;
      endcase
`ifdef FFT_SRC_ZERO_PAD_EN
      if (w_pad_go) w_next = ST_PAD;
`endif
   end

   assign w_re_x = MAN_W'($signed(in_real_i));
   assign w_im_x = MAN_W'($signed(in_imag_i));

   // Output decode: what goes out with this cycle's transfer
   always_comb begin
      w_pad = (r_state == ST_PAD);
      w_val = w_start | w_blk_inc;
      w_err = (r_state == ST_IDLE) & w_xfer & ~w_ldn_ok;
      w_re  = w_pad ? '0 : w_re_x;
      w_im  = w_pad ? '0 : w_im_x;
   end

   // Output registers; ldn is latched only at a block start
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         r_val  <= 1'b0;
         r_sync <= 1'b0;
         r_err  <= 1'b0;
         r_re   <= '0;
         r_im   <= '0;
         r_exp  <= '0;
         r_ldn  <= '0;
      end else begin
         r_val  <= w_val;
         r_sync <= w_start;
         r_err  <= w_err;
         r_re   <= w_re;
         r_im   <= w_im;
         r_exp  <= w_val ? EXP_INIT : '0;
         if (w_start)
            r_ldn <= ldn_rg_i;
      end
   end

   assign data_val_o   = r_val;
   assign block_sync_o = r_sync;
   assign stage_sync_o = r_sync;
   assign cfg_err_o    = r_err;
   assign data_real_o  = r_re;
   assign data_imag_o  = r_im;
   assign data_exp_o   = r_exp;
   assign ldn_rg_o     = r_ldn;

endmodule

// File: tb/tb_fft_stream_src.sv
// Bench for fft_stream_src: directed steps with random sample data,
// expected outputs derived per sample from the framing rules.

module tb_fft_stream_src;
   import fft_pkg::*;

   localparam int MW = MAN_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic val = 1'b0;
   logic vz = 1'b0;
   logic last = 1'b0;
   logic [15:0] re = '0;
   logic [15:0] im = '0;
   logic [3:0] ldn = '0;

   logic rdy, bs, ss, dv, er;
   logic [MW-1:0] dr, di;
   logic [EXP_W-1:0] de;
   logic [3:0] lr;

   logic rdyz, bsz, ssz, dvz, erz;
   logic [MW-1:0] drz, diz;
   logic [EXP_W-1:0] dez;
   logic [3:0] lrz;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fft_stream_src #(.IN_WIDTH(16), .MIN_GAP(4)) dut (
      .clk_sys(clk), .rst_sys(rst),
      .in_val_i(val), .in_rdy_o(rdy),
      .in_real_i(re), .in_imag_i(im),
      .in_last_i(last), .ldn_rg_i(ldn),
      .block_sync_o(bs), .stage_sync_o(ss),
      .data_val_o(dv), .data_real_o(dr),
      .data_imag_o(di), .data_exp_o(de),
      .ldn_rg_o(lr), .cfg_err_o(er)
   );

   fft_stream_src #(.IN_WIDTH(16), .MIN_GAP(0)) dz (
      .clk_sys(clk), .rst_sys(rst),
      .in_val_i(vz), .in_rdy_o(rdyz),
      .in_real_i(re), .in_imag_i(im),
      .in_last_i(last), .ldn_rg_i(ldn),
      .block_sync_o(bsz), .stage_sync_o(ssz),
      .data_val_o(dvz), .data_real_o(drz),
      .data_imag_o(diz), .data_exp_o(dez),
      .ldn_rg_o(lrz), .cfg_err_o(erz)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference sign extension of a 16-bit sample to the mantissa width
   function automatic logic [31:0] sx(input logic [15:0] x);
      int v;
      logic [31:0] o;
      v = $signed(x);
      o = '0;
      o[MW-1:0] = v[MW-1:0];
      return o;
   endfunction

   // One accepted sample, k-th of a block of size 2^l
   task automatic xfer(input int k, input int l, input logic [15:0] r,
                       input logic [15:0] i, input bit lst);
      chk("rdy_before", 32'(rdy), 1);
      val = 1'b1;
      re = r;
      im = i;
      last = lst;
      ldn = (k == 0) ? 4'(l) : 4'($urandom_range(15, 0));
      cyc();
      val = 1'b0;
      last = 1'b0;
      chk("dval", 32'(dv), 1);
      chk("bsync", 32'(bs), 32'(k == 0));
      chk("ssync", 32'(ss), 32'(k == 0));
      chk("real", 32'(dr), sx(r));
      chk("imag", 32'(di), sx(i));
      chk("exp", 32'(de), 0);
      chk("ldn_rg", 32'(lr), 32'(l));
      chk("cfg_err", 32'(er), 0);
   endtask

   task automatic send_blk(input int l, input int maxgap, input bit seq);
      int n;
      logic [15:0] r;
      n = 1 << l;
      for (int k = 0; k < n; k++) begin
         if (k > 0) begin
            repeat ($urandom_range(maxgap, 0)) begin
               cyc();
               chk("midgap_dval", 32'(dv), 0);
            end
         end
         r = seq ? 16'(k + 1) : 16'($urandom);
         xfer(k, l, r, 16'($urandom), 1'b0);
      end
   endtask

   // Four refused cycles after a block, upstream still offering data
   task automatic gap_chk();
      for (int g = 0; g < 4; g++) begin
         chk("gap_rdy", 32'(rdy), 0);
         val = 1'b1;
         re = 16'($urandom);
         ldn = 4'd3;
         cyc();
         chk("gap_dval", 32'(dv), 0);
      end
      val = 1'b0;
      chk("post_gap_rdy", 32'(rdy), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      #2;
      chk("rst_dval", 32'(dv), 0);
      chk("rst_bsync", 32'(bs), 0);
      chk("rst_ssync", 32'(ss), 0);
      chk("rst_err", 32'(er), 0);
      chk("rst_ldn", 32'(lr), 0);
      chk("rst_real", 32'(dr), 0);
      chk("rst_exp", 32'(de), 0);
      chk("rst_rdy", 32'(rdy), 0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("rdy_out_of_rst", 32'(rdy), 1);

      // T1: 16-point block, samples 1..16 back to back, then gap
      send_blk(4, 0, 1'b1);
      gap_chk();

      // Random sizes, random data, random mid-block gaps
      repeat (4) begin
         send_blk($urandom_range(5, 2), 2, 1'b0);
         gap_chk();
      end

      // T3: illegal sizes refused, then an 8-point block
      for (int t = 0; t < 3; t++) begin
         ldn = (t == 0) ? 4'd12 : ((t == 1) ? 4'd1 : 4'd15);
         val = 1'b1;
         re = 16'($urandom);
         cyc();
         val = 1'b0;
         chk("t3_err", 32'(er), 1);
         chk("t3_dval", 32'(dv), 0);
         chk("t3_bsync", 32'(bs), 0);
         chk("t3_rdy", 32'(rdy), 1);
         cyc();
         chk("t3_err_pulse", 32'(er), 0);
      end
      send_blk(3, 1, 1'b0);
      gap_chk();

      // T4: most negative input sign-extends into the mantissa
      xfer(0, 2, 16'h8000, 16'h7fff, 1'b0);
      chk("t4_real", 32'(dr), 32'h38000);
      chk("t4_imag", 32'(di), 32'h07fff);
      for (int k = 1; k < 4; k++)
         xfer(k, 2, 16'($urandom), 16'($urandom), 1'b0);
      gap_chk();

      // T5: reset after sample 5 of a 16-point block
      for (int k = 0; k < 5; k++)
         xfer(k, 4, 16'($urandom), 16'($urandom), 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_dval", 32'(dv), 0);
      chk("t5_bsync", 32'(bs), 0);
      chk("t5_rdy", 32'(rdy), 0);
      chk("t5_ldn", 32'(lr), 0);
      chk("t5_real", 32'(dr), 0);
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk("t5_rdy_rel", 32'(rdy), 1);
      send_blk(2, 1, 1'b0);
      gap_chk();

      // T2: no-gap instance, two 4-point blocks back to back
      for (int k = 0; k < 8; k++) begin
         chk("t2_rdy", 32'(rdyz), 1);
         vz = 1'b1;
         r = 16'($urandom);
         re = r;
         ldn = 4'd2;
         cyc();
         chk("t2_dval", 32'(dvz), 1);
         chk("t2_bsync", 32'(bsz), 32'((k % 4) == 0));
         chk("t2_real", 32'(drz), sx(r));
         chk("t2_ldn", 32'(lrz), 2);
      end
      vz = 1'b0;
      cyc();
      chk("t2_idle_dval", 32'(dvz), 0);

`ifdef FFT_SRC_ZERO_PAD_EN
      // T6: 8-point block closed early after sample 5
      for (int k = 0; k < 5; k++)
         xfer(k, 3, 16'($urandom), 16'($urandom), k == 4);
      for (int p = 0; p < 3; p++) begin
         chk("t6_rdy", 32'(rdy), 0);
         cyc();
         chk("t6_dval", 32'(dv), 1);
         chk("t6_real", 32'(dr), 0);
         chk("t6_imag", 32'(di), 0);
         chk("t6_bsync", 32'(bs), 0);
      end
      gap_chk();
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
